// File: rtl/demux4_fifo.sv
// -----------------------------------------------------------------------------
// demux4_fifo
//
// Buffered 1-to-4 demultiplexer. Each 32-bit input word is steered to one of
// four consumer lanes chosen by in_sel. Every lane has its own small FIFO, so a
// stalled consumer blocks only words addressed to its own lane.
//
// Optional feature macro: DEMUX4_BCAST_EN
//   When defined, the in_bcast input exists. An accepted word with in_bcast = 1
//   is written to all four lanes, and in_ready then requires that no lane is
//   full. When undefined, the block is unicast only and has no in_bcast port.
//
// Parameters
//   DW     data width of every word
//   DEPTH  entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word
//   in_ready   word can be accepted this cycle (target lane(s) not full)
//   in_sel     destination lane 0..3
//   in_data    input word
//   in_bcast   broadcast request (DEMUX4_BCAST_EN only)
//   out_valid  bit k set while lane k holds at least one word
//   out_ready  bit k set when consumer k takes its head word
//   out_data0..out_data3  head word of each lane (stale while out_valid[k] = 0)
//   xfer_cnt   count of accepted input words, wraps at 16 bits
// -----------------------------------------------------------------------------
module demux4_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_sel,
  input  logic [DW-1:0] in_data,
`ifdef DEMUX4_BCAST_EN
  input  logic          in_bcast,
`endif
  output logic [3:0]    out_valid,
  input  logic [3:0]    out_ready,
  output logic [DW-1:0] out_data0,
  output logic [DW-1:0] out_data1,
  output logic [DW-1:0] out_data2,
  output logic [DW-1:0] out_data3,
  output logic [15:0]   xfer_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [3:0]    full;
  logic [3:0]    push;
  logic [3:0]    pop;
  logic          accept;
  logic [DW-1:0] head [4];

  // Readiness looks only at occupancy, never at out_ready, so a full lane
  // refuses input even in a cycle where it is popping.
  always_comb begin
`ifdef DEMUX4_BCAST_EN
    if (in_bcast) begin
      in_ready = ~|full;
    end else begin
      in_ready = ~full[in_sel];
    end
`else
    in_ready = ~full[in_sel];
`endif
  end

  assign accept = in_valid && in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [DW-1:0] mem [DEPTH];
      logic [PW-1:0] wr_ptr_reg;
      logic [PW-1:0] rd_ptr_reg;
      logic [CW-1:0] count_reg;

      assign full[gi]      = (count_reg == FULL_CNT);
      assign out_valid[gi] = (count_reg != '0);
      assign pop[gi]       = out_valid[gi] && out_ready[gi];
      assign head[gi]      = mem[rd_ptr_reg];

`ifdef DEMUX4_BCAST_EN
      assign push[gi] = accept && (in_bcast || (in_sel == 2'(gi)));
`else
      assign push[gi] = accept && (in_sel == 2'(gi));
`endif

      // Storage is cleared on reset so an empty lane reads back 0 afterwards.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
          end
        end else if (push[gi]) begin
          mem[wr_ptr_reg] <= in_data;
        end
      end

      // Pointers wrap naturally because DEPTH is a power of two.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
          end
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign out_data0 = head[0];
  assign out_data1 = head[1];
  assign out_data2 = head[2];
  assign out_data3 = head[3];

  // One count per accepted word, including a broadcast word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (accept) begin
      xfer_cnt <= xfer_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_demux4_fifo.sv
// -----------------------------------------------------------------------------
// tb_demux4_fifo
//
// Directed testbench for demux4_fifo (DW = 32, DEPTH = 2). Inputs change on the
// falling clock edge; registered outputs are sampled 1 ns after the rising edge.
// Broadcast steps are compiled in only when DEMUX4_BCAST_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux4_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sel;
  logic [31:0] in_data;
`ifdef DEMUX4_BCAST_EN
  logic        in_bcast;
`endif
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data0;
  logic [31:0] out_data1;
  logic [31:0] out_data2;
  logic [31:0] out_data3;
  logic [15:0] xfer_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  demux4_fifo #(.DW(32), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
`ifdef DEMUX4_BCAST_EN
    .in_bcast  (in_bcast),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .xfer_cnt  (xfer_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] od(input int k);
    case (k)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  // One accepted word: drive at the falling edge, expect in_ready, clock it in.
  task automatic push_word(input logic [1:0] sel, input logic [31:0] data, input bit quiet);
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    #1;
    if (!quiet) chk("push_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!quiet) $display("push lane=%0d data=0x%0h xfer_cnt=%0d out_valid=%b",
                         sel, data, xfer_cnt, out_valid);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 32'd0;
    out_ready = 4'b0000;
`ifdef DEMUX4_BCAST_EN
    in_bcast  = 1'b0;
`endif

    // ---- reset state ----
    #12;
    chk("rst_out_valid", {28'd0, out_valid}, 32'h0);
    chk("rst_data0", out_data0, 32'h0);
    chk("rst_data1", out_data1, 32'h0);
    chk("rst_data2", out_data2, 32'h0);
    chk("rst_data3", out_data3, 32'h0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- unicast to each lane, consumers always ready ----
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      push_word(2'(k), 32'hA0 + 32'(k), 1'b0);
      chk("uni_out_valid", {28'd0, out_valid}, 32'(1 << k));
      chk("uni_out_data", od(k), 32'hA0 + 32'(k));
    end
    chk("uni_xfer_cnt", {16'd0, xfer_cnt}, 32'd4);
    @(posedge clk);
    #1;
    chk("uni_drained", {28'd0, out_valid}, 32'h0);

    // ---- fill lane 2 while its consumer stalls ----
    out_ready = 4'b1011;
    push_word(2'd2, 32'h11, 1'b0);
    push_word(2'd2, 32'h22, 1'b0);
    @(negedge clk);
    in_sel = 2'd2;
    #1;
    chk("full_ready_lane2", {31'd0, in_ready}, 32'd0);
    in_sel = 2'd0;
    #1;
    chk("full_ready_lane0", {31'd0, in_ready}, 32'd1);
    chk("full_out_valid", {28'd0, out_valid}, 32'h4);
    chk("full_head", out_data2, 32'h11);
    // A word offered to the full lane must be refused.
    in_valid = 1'b1;
    in_sel   = 2'd2;
    in_data  = 32'h33;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("full_refused_cnt", {16'd0, xfer_cnt}, 32'd6);
    chk("full_refused_head", out_data2, 32'h11);
    // Popping does not make the full lane ready in the same cycle.
    @(negedge clk);
    out_ready = 4'b1111;
    in_sel    = 2'd2;
    #1;
    chk("full_ready_while_pop", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("pop1_head", out_data2, 32'h22);
    chk("pop1_valid", {28'd0, out_valid}, 32'h4);
    chk("pop1_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk("pop2_valid", {28'd0, out_valid}, 32'h0);

    // ---- lane 3 holds one word, then streams with push and pop together ----
    out_ready = 4'b0111;
    push_word(2'd3, 32'hB0, 1'b0);
    chk("hold_head", out_data3, 32'hB0);
    @(negedge clk);
    out_ready = 4'b1111;
    for (int i = 1; i <= 8; i++) begin
      push_word(2'd3, 32'hB0 + 32'(i), 1'b0);
      chk("stream_head", out_data3, 32'hB0 + 32'(i));
      chk("stream_valid", {28'd0, out_valid}, 32'h8);
    end
    @(posedge clk);
    #1;
    chk("stream_drained", {28'd0, out_valid}, 32'h0);
    chk("stream_xfer_cnt", {16'd0, xfer_cnt}, 32'd15);

    // ---- asynchronous reset with two words parked in lane 1 ----
    out_ready = 4'b1101;
    push_word(2'd1, 32'hC1, 1'b0);
    push_word(2'd1, 32'hC2, 1'b0);
    chk("pre_rst_valid", {28'd0, out_valid}, 32'h2);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {28'd0, out_valid}, 32'h0);
    chk("async_rst_data1", out_data1, 32'h0);
    chk("async_rst_xfer", {16'd0, xfer_cnt}, 32'd0);
    chk("async_rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef DEMUX4_BCAST_EN
    // ---- broadcast ----
    out_ready = 4'b0000;
    @(negedge clk);
    in_valid = 1'b1;
    in_bcast = 1'b1;
    in_sel   = 2'd2;
    in_data  = 32'h5A;
    #1;
    chk("bc_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bcast = 1'b0;
    $display("bcast data=0x5a xfer_cnt=%0d out_valid=%b", xfer_cnt, out_valid);
    chk("bc_valid", {28'd0, out_valid}, 32'hF);
    for (int k = 0; k < 4; k++) chk("bc_data", od(k), 32'h5A);
    chk("bc_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);
    push_word(2'd0, 32'h77, 1'b0);
    @(negedge clk);
    in_bcast = 1'b1;
    #1;
    chk("bc_ready_lane0_full", {31'd0, in_ready}, 32'd0);
    in_bcast = 1'b0;
    in_sel   = 2'd1;
    #1;
    chk("uc_ready_lane1", {31'd0, in_ready}, 32'd1);
`endif

    // ---- 16-bit counter wrap: 65,537 accepted words ----
    do_reset();
    out_ready = 4'b1111;
    for (int i = 0; i < 65537; i++) begin
      push_word(2'(i), 32'(i), 1'b1);
      if (i == 65535) chk("wrap_zero", {16'd0, xfer_cnt}, 32'd0);
    end
    $display("wrap xfer_cnt=%0d out_valid=%b", xfer_cnt, out_valid);
    chk("wrap_xfer_cnt", {16'd0, xfer_cnt}, 32'd1);
    chk("wrap_valid", {28'd0, out_valid}, 32'h1);
    chk("wrap_data0", out_data0, 32'h10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux4_fifo.md
# demux4_fifo

Buffered 1-to-4 demultiplexer: steers 32-bit words from a single producer to one of four consumers selected per word by a 2-bit lane index. It is the distributing counterpart of the datapath's 4:1 select muxes and feeds write-back or result consumers that cannot always accept data in the cycle it is produced. Each lane has its own small FIFO, so a stalled consumer blocks only words addressed to its own lane.

## Interface
- `DW`, 32, data width of every word.
- `DEPTH`, 2, entries per lane FIFO; power of two, at least 2.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  producer has a word.
- `in_ready`  output  1  the word can be accepted this cycle.
- `in_sel`  input  2  destination lane, 0..3.
- `in_data`  input  DW  word.
- `out_valid`  output  4  bit k set while lane k FIFO is non-empty.
- `out_ready`  input  4  bit k set when consumer k takes its head word.
- `out_data0` .. `out_data3`  output  DW each  head word of lane 0..3.
- `xfer_cnt`  output  16  count of accepted input words, wraps.
- `in_bcast`  input  1  broadcast request; exists only with `DEMUX4_BCAST_EN`.

## Operation
- Input handshake: a word is accepted when `in_valid && in_ready` at a rising edge. `in_ready` is combinational from `in_sel` and lane occupancy: it is 1 iff lane `in_sel` is not full.
- `in_ready` does not depend on the same-cycle `out_ready`, so a full lane refuses input even when it is popping in that cycle.
- An accepted word is written at the tail of lane `in_sel`. It is never written to any other lane.
- Each lane FIFO has read and write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
- A lane is full when its count equals DEPTH and empty when its count is 0.
- Output handshake, lane k: a pop happens when `out_valid[k] && out_ready[k]`. `out_data_k` always shows the head entry. It is 0 when the lane is empty after reset; otherwise it holds stale storage, which consumers must ignore while `out_valid[k]` is 0.
- If the same lane pushes and pops in one cycle (possible only when it is not full), its count is unchanged and both pointers advance.
- The lanes are fully independent; pops on all four lanes and a push on any one lane can happen in the same cycle.
- `xfer_cnt` increments by 1 on every accepted input word and wraps from 0xFFFF to 0x0000.
- `out_ready[k]` asserted while `out_valid[k]` is 0 has no effect.
- `in_sel` and `in_data` are don't-care when `in_valid` is 0.
- No state machine is used: the behaviour comes entirely from the per-lane pointer and count state.

## Timing
- Reset (asynchronous assert when `rst_n` = 0): all pointers and counts go to 0, all storage goes to 0 and `xfer_cnt` goes to 0.
- Reset values of outputs: `out_valid` = 4'b0000, all `out_data*` = 0, `xfer_cnt` = 0. `in_ready` = 1, because every lane is empty.
- Reset mid-operation discards all buffered words immediately. Deassertion is released to the next rising edge.
- Latency: a word accepted at edge N is visible on `out_valid`/`out_data` of an empty lane after edge N. There is no same-cycle pass-through.
- Throughput: one input word per cycle as long as the target lane is not full. Each lane delivers one word per cycle.
- Order: words are delivered in acceptance order within a lane. No ordering is guaranteed across lanes.

## Configuration
- `DEMUX4_BCAST_EN` defined: the `in_bcast` port exists.
  - With `in_bcast` = 1, an accepted word is pushed into all four lanes and `in_sel` is ignored.
  - In that case `in_ready` = 1 iff no lane is full.
  - `xfer_cnt` increments by 1 per broadcast word, not by 4.
- `DEMUX4_BCAST_EN` undefined: the `in_bcast` port and all broadcast logic are absent, and the block behaves as unicast only.

## Test plan
- Reset then idle: `out_valid` = 0000, `out_data0..3` = 0, `in_ready` = 1 and `xfer_cnt` = 0. Assert `rst_n` low mid-stream with 2 words in lane 1: `out_valid` drops to 0000 asynchronously.
- Unicast: send 0xA0, 0xA1, 0xA2, 0xA3 to lanes 0, 1, 2, 3 with all `out_ready` = 1. Each lane shows its word one cycle after acceptance, and `xfer_cnt` = 4.
- Full lane with DEPTH = 2: hold `out_ready[2]` = 0 and push 0x11, 0x22 to lane 2. `in_ready` then goes 0 for `in_sel` = 2 but stays 1 for `in_sel` = 0. Raising `out_ready[2]` pops 0x11 then 0x22 in order, and `in_ready` returns to 1.
- Simultaneous push/pop: lane 3 holds one word with `out_ready[3]` = 1 while a new word is pushed. The count stays at 1 and there is a continuous 1-per-cycle stream over 8 words with no loss.
- Counter wrap: accept 65,537 words. `xfer_cnt` = 1.
- With `DEMUX4_BCAST_EN` defined and `in_bcast` = 1 for word 0x5A: all four lanes show 0x5A and `xfer_cnt` increments by 1. With lane 0 full, `in_ready` = 0 for a broadcast.
